pipelined_carry_select_adder: RTL

//  Parametrised, pipelined carry-select add/sub unit; successor to the 32-bit combinational CSA.

---
 rtl/pipelined_carry_select_adder_pkg.sv | 14 +
 rtl/pipelined_carry_select_adder_if.sv | 27 ++
 rtl/pipelined_carry_select_adder_csa_group.sv | 27 ++
 rtl/pipelined_carry_select_adder.sv | 115 +++++++++++
 4 files changed

// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared definitions for the pipelined carry-select add/sub unit:
// operation encoding and the group-count helper used to size the datapath.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int group_count(input int n, input int blk);
        return n / blk;
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder.
// master = operand producer and result consumer, slave = the adder.
interface pipelined_carry_select_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_carry_select_adder_csa_group.sv
// BLK-bit carry-select group: precomputes sums for carry 0 and 1, the incoming carry picks one.
// Latency: combinational. Backpressure: none, pure datapath.
// DUAL=0 gives the plain ripple form for the first group of a slice, whose carry is already known.
module csa_group #(
    parameter int BLK  = 4,
    parameter bit DUAL = 1'b1
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);
    if (DUAL) begin : g_dual
        logic [BLK:0] r0;
        logic [BLK:0] r1;
        assign r0   = {1'b0, a} + {1'b0, b};
        assign r1   = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
        assign sum  = cin ? r1[BLK-1:0] : r0[BLK-1:0];
        assign cout = cin ? r1[BLK] : r0[BLK];
    end else begin : g_direct
        logic [BLK:0] r;
        assign r    = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, cin};
        assign sum  = r[BLK-1:0];
        assign cout = r[BLK];
    end
endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select add/sub: A + (op_sub ? ~B : B) + cin, split into STAGES slices of BLK-bit groups.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle while the consumer keeps up.
// Backpressure: global stall, every stage holds while out_valid && !out_ready; in_ready mirrors it.
module pipelined_carry_select_adder
    import adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    pipelined_carry_select_adder_if.slave ifc
);
    localparam int W = N / STAGES;
    localparam int G = group_count(N, BLK) / STAGES;

    if (BLK < 2 || STAGES < 1 || (N % (BLK * STAGES)) != 0) begin : g_bad_cfg
        $error("pipelined_carry_select_adder: N must be a multiple of BLK*STAGES, BLK>=2, STAGES>=1");
    end

    logic         adv;
    logic [N-1:0] b_eff;

    assign adv          = !ifc.out_valid || ifc.out_ready;
    assign ifc.in_ready = adv;
    assign b_eff        = (op_e'(ifc.op_sub) == OP_SUB) ? ~ifc.b : ifc.b;

    // Stage k consumes operand bits [LO +: W]; bits above HI ride along (skew) and
    // finished sum bits below LO ride along (deskew) so the whole word exits together.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;
        localparam int HI = LO + W;

        logic            vld_in;
        logic            c_in;
        logic            vld_q;
        logic            c_q;
        logic [N-LO-1:0] a_in;
        logic [N-LO-1:0] b_in;
        logic [G:0]      gc;
        logic [W-1:0]    slice_sum;
        logic [HI-1:0]   sum_d;
        logic [HI-1:0]   sum_q;

        if (k == 0) begin : g_head
            assign vld_in = ifc.in_valid;
            assign c_in   = ifc.cin;
            assign a_in   = ifc.a;
            assign b_in   = b_eff;
            assign sum_d  = slice_sum;
        end else begin : g_body
            assign vld_in = g_stage[k-1].vld_q;
            assign c_in   = g_stage[k-1].c_q;
            assign a_in   = g_stage[k-1].g_skew.a_q;
            assign b_in   = g_stage[k-1].g_skew.b_q;
            assign sum_d  = {slice_sum, g_stage[k-1].sum_q};
        end

        assign gc[0] = c_in;
        for (genvar j = 0; j < G; j++) begin : g_grp
            csa_group #(
                .BLK  (BLK),
                .DUAL (j != 0)
            ) u_grp (
                .a    (a_in[j*BLK +: BLK]),
                .b    (b_in[j*BLK +: BLK]),
                .cin  (gc[j]),
                .sum  (slice_sum[j*BLK +: BLK]),
                .cout (gc[j+1])
            );
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                if (vld_in) begin
                    c_q   <= gc[G];
                    sum_q <= sum_d;
                end
            end
        end

        if (HI < N) begin : g_skew
            logic [N-HI-1:0] a_q;
            logic [N-HI-1:0] b_q;
            always_ff @(posedge clk) begin
                if (adv && vld_in) begin
                    a_q <= a_in[N-LO-1:W];
                    b_q <= b_in[N-LO-1:W];
                end
            end
        end else begin : g_tail
            // Top slice sees a[N-1] and b_eff[N-1] directly, so the sign check lives here.
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && vld_in) begin
                    ovf_q <= (a_in[W-1] == b_in[W-1]) && (slice_sum[W-1] != a_in[W-1]);
                end
            end
        end
    end

    assign ifc.out_valid = g_stage[STAGES-1].vld_q;
    assign ifc.sum       = g_stage[STAGES-1].sum_q;
    assign ifc.cout      = g_stage[STAGES-1].c_q;
    assign ifc.overflow  = g_stage[STAGES-1].g_tail.ovf_q;

endmodule
